// File: rtl/viol_reset_seq_pkg.sv
// Shared definitions for the violation reset sequencer and the access-control monitors.
// Holds the sequencer state encoding, the trusted-memory/reset-vector defaults and a
// helper that tells whether an address lies inside the trusted code region.
package viol_reset_seq_pkg;

    typedef enum logic [1:0] {
        StIdle        = 2'b00,
        StHold        = 2'b01,
        StWaitHandler = 2'b10
    } state_e;

    localparam logic [15:0] RESET_HANDLER_DEF = 16'hfffe;
    localparam logic [15:0] SMEM_BASE_DEF     = 16'hA000;
    localparam logic [15:0] SMEM_SIZE_DEF     = 16'h4000;

    // The last trusted word starts at base + size - 2; widened so the sum cannot wrap.
    function automatic logic in_smem(input logic [15:0] addr,
                                     input logic [15:0] base,
                                     input logic [15:0] size);
        logic [16:0] last;
        last = {1'b0, base} + {1'b0, size} - 17'd2;
        return ({1'b0, addr} >= {1'b0, base}) && ({1'b0, addr} <= last);
    endfunction

endpackage

// File: rtl/viol_reset_seq_if.sv
// Kill/reset interface between the monitors + core and the violation reset sequencer.
//   kill_vec     : level kill requests, one bit per monitor
//   pc           : current program counter of the core
//   clr_req      : request to clear the sticky cause/timeout flags
//   cpu_rst      : registered reset to the core
//   busy         : sequencer not idle
//   rst_cause    : sticky OR of kill bits seen
//   timeout_flag : sticky, reset handler not reached in time
//   viol_cnt     : saturating count of reset episodes
// master = monitor/core side, slave = sequencer.
interface viol_reset_seq_if #(
    parameter int unsigned N_SRC = 3,
    parameter int unsigned CNT_W = 8
);
    logic [N_SRC-1:0] kill_vec;
    logic [15:0]      pc;
    logic             clr_req;
    logic             cpu_rst;
    logic             busy;
    logic [N_SRC-1:0] rst_cause;
    logic             timeout_flag;
    logic [CNT_W-1:0] viol_cnt;

    modport master (
        output kill_vec, pc, clr_req,
        input  cpu_rst, busy, rst_cause, timeout_flag, viol_cnt
    );

    modport slave (
        input  kill_vec, pc, clr_req,
        output cpu_rst, busy, rst_cause, timeout_flag, viol_cnt
    );
endinterface

// File: rtl/viol_reset_seq_sat_counter.sv
// Width-parameterised saturating up-counter.
//   clk, reset : clock and asynchronous active-high reset (count -> 0)
//   inc        : increment request, ignored once the count is all-ones
//   count      : registered count value
module viol_reset_seq_sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;
endmodule

// File: rtl/viol_reset_seq.sv
// Violation reset sequencer: turns monitor kill requests into a timed CPU reset pulse,
// then watches the core re-enter through the reset vector, re-pulsing on timeout.
//   clk, reset : clock and asynchronous active-high reset
//   bus        : slave side of viol_reset_seq_if (kill_vec/pc/clr_req in,
//                cpu_rst/busy/rst_cause/timeout_flag/viol_cnt out, all registered)
module viol_reset_seq
    import viol_reset_seq_pkg::*;
#(
    parameter int unsigned N_SRC         = 3,
    parameter int unsigned RST_CYCLES    = 4,
    parameter logic [15:0] WAIT_TIMEOUT  = 16'd64,
    parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEF,
    parameter logic [15:0] SMEM_BASE     = SMEM_BASE_DEF,
    parameter logic [15:0] SMEM_SIZE     = SMEM_SIZE_DEF,
    parameter int unsigned CNT_W         = 8
) (
    input logic            clk,
    input logic            reset,
    viol_reset_seq_if.slave bus
);
    localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(RST_CYCLES - 1);

    state_e           state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [15:0]      wait_q, wait_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             busy_q, busy_d;
    logic [N_SRC-1:0] cause_q, cause_d;
    logic             tflag_q, tflag_d;
    logic             viol_inc;

    logic kill_any;
    logic at_handler;
    logic timeout_hit;
    logic clr_ok;

    assign kill_any    = |bus.kill_vec;
    assign at_handler  = (bus.pc == RESET_HANDLER);
    assign timeout_hit = (wait_q == (WAIT_TIMEOUT - 16'd1));
    assign clr_ok      = bus.clr_req && in_smem(bus.pc, SMEM_BASE, SMEM_SIZE);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (kill_any) state_d = StHold;
            end
            StHold: begin
                // A kill in HOLD extends the pulse, so it wins over release.
                if (!kill_any && (hold_q == '0)) state_d = StWaitHandler;
            end
            StWaitHandler: begin
                if (kill_any)         state_d = StHold;
                else if (at_handler)  state_d = StIdle;
                else if (timeout_hit) state_d = StHold;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        cpu_rst_d = 1'b0;
        hold_d    = hold_q;
        wait_d    = wait_q;
        cause_d   = cause_q;
        tflag_d   = tflag_q;
        viol_inc  = 1'b0;
        case (state_q)
            StIdle: begin
                if (kill_any) begin
                    cpu_rst_d = 1'b1;
                    hold_d    = HOLD_RELOAD;
                    cause_d   = cause_q | bus.kill_vec;
                    viol_inc  = 1'b1;
                end else if (clr_ok) begin
                    cause_d = '0;
                    tflag_d = 1'b0;
                end
            end
            StHold: begin
                cpu_rst_d = 1'b1;
                if (kill_any) begin
                    // Same episode: extend without counting again.
                    cause_d = cause_q | bus.kill_vec;
                    hold_d  = HOLD_RELOAD;
                end else if (hold_q == '0) begin
                    cpu_rst_d = 1'b0;
                    wait_d    = '0;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            StWaitHandler: begin
                wait_d = wait_q + 16'd1;
                if (kill_any) begin
                    cpu_rst_d = 1'b1;
                    hold_d    = HOLD_RELOAD;
                    cause_d   = cause_q | bus.kill_vec;
                    viol_inc  = 1'b1;
                end else if (!at_handler && timeout_hit) begin
                    tflag_d   = 1'b1;
                    cpu_rst_d = 1'b1;
                    hold_d    = HOLD_RELOAD;
                    viol_inc  = 1'b1;
                end
            end
            default: ;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q    <= '0;
            wait_q    <= '0;
            cpu_rst_q <= 1'b0;
            busy_q    <= 1'b0;
            cause_q   <= '0;
            tflag_q   <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            wait_q    <= wait_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q    <= busy_d;
            cause_q   <= cause_d;
            tflag_q   <= tflag_d;
        end
    end

    viol_reset_seq_sat_counter #(
        .WIDTH(CNT_W)
    ) u_viol_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (viol_inc),
        .count(bus.viol_cnt)
    );

    assign bus.cpu_rst      = cpu_rst_q;
    assign bus.busy         = busy_q;
    assign bus.rst_cause    = cause_q;
    assign bus.timeout_flag = tflag_q;
endmodule

// File: tb/tb_viol_reset_seq.sv
// Self-checking bench for viol_reset_seq: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a behavioural model.
module tb_viol_reset_seq;
    localparam int RST_CYCLES = 4;
    localparam int WAIT_TO    = 64;

    logic clk;
    logic reset;

    viol_reset_seq_if #(.N_SRC(3), .CNT_W(8)) bus ();

    viol_reset_seq #(
        .N_SRC        (3),
        .RST_CYCLES   (RST_CYCLES),
        .WAIT_TIMEOUT (16'd64),
        .RESET_HANDLER(16'hfffe),
        .SMEM_BASE    (16'hA000),
        .SMEM_SIZE    (16'h4000),
        .CNT_W        (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: remaining pulse cycles, waiting-for-vector flag, elapsed wait.
    typedef struct {
        int         left;
        bit         waiting;
        int         el;
        logic [2:0] cause;
        bit         tf;
        int         viol;
    } model_t;

    model_t m;

    function automatic model_t start_episode(input model_t c, input logic [2:0] kv);
        model_t n = c;
        n.waiting = 1'b0;
        n.left    = RST_CYCLES;
        n.cause   = c.cause | kv;
        if (c.viol < 255) n.viol = c.viol + 1;
        return n;
    endfunction

    function automatic model_t model_next(input model_t c, input logic [2:0] kv,
                                          input logic [15:0] p, input logic clr);
        model_t n = c;
        if (c.left > 0) begin
            if (kv != 3'b000) begin
                n.cause = c.cause | kv;
                n.left  = RST_CYCLES;
            end else begin
                n.left = c.left - 1;
                if (n.left == 0) begin
                    n.waiting = 1'b1;
                    n.el      = 0;
                end
            end
        end else if (c.waiting) begin
            if (kv != 3'b000) begin
                n = start_episode(c, kv);
            end else if (p == 16'hfffe) begin
                n.waiting = 1'b0;
            end else if (c.el == WAIT_TO - 1) begin
                n    = start_episode(c, 3'b000);
                n.tf = 1'b1;
            end else begin
                n.el = c.el + 1;
            end
        end else begin
            if (kv != 3'b000) begin
                n = start_episode(c, kv);
            end else if (clr && (p >= 16'hA000) && (p <= 16'hDFFE)) begin
                n.cause = 3'b000;
                n.tf    = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '{left: 0, waiting: 1'b0, el: 0, cause: 3'b000, tf: 1'b0, viol: 0};
        else       m <= model_next(m, bus.kill_vec, bus.pc, bus.clr_req);
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("cpu_rst",      32'(bus.cpu_rst),      32'(m.left > 0));
            check("busy",         32'(bus.busy),         32'((m.left > 0) || m.waiting));
            check("rst_cause",    32'(bus.rst_cause),    32'(m.cause));
            check("timeout_flag", 32'(bus.timeout_flag), 32'(m.tf));
            check("viol_cnt",     32'(bus.viol_cnt),     32'(m.viol));
        end
    end

    task automatic do_reset();
        reset        = 1'b1;
        bus.kill_vec = 3'b000;
        bus.pc       = 16'h0000;
        bus.clr_req  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts negedges with cpu_rst high starting from the current one.
    task automatic count_high(output int hi);
        hi = 0;
        while (bus.cpu_rst && hi < 50) begin
            hi++;
            @(negedge clk);
        end
    endtask

    task automatic go_idle();
        int n = 0;
        bus.pc = 16'hfffe;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("go_idle_bound", 32'(bus.busy), 32'd0);
        bus.pc = 16'h0000;
    endtask

    task automatic pulse_kill(input logic [2:0] kv);
        bus.kill_vec = kv;
        @(negedge clk);
        bus.kill_vec = 3'b000;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int hi;
        int w;
        do_reset();
        check("reset_cpu_rst", 32'(bus.cpu_rst), 32'd0);
        check("reset_busy",    32'(bus.busy),    32'd0);
        check("reset_viol",    32'(bus.viol_cnt), 32'd0);

        // Single episode
        pulse_kill(3'b001);
        check("t1_cause", 32'(bus.rst_cause), 32'h1);
        check("t1_viol",  32'(bus.viol_cnt),  32'd1);
        check("t1_busy",  32'(bus.busy),      32'd1);
        count_high(hi);
        check("t1_rst_len", 32'(hi), 32'd4);
        bus.pc = 16'hfffe;
        @(negedge clk);
        bus.pc = 16'h0000;
        check("t1_idle", 32'(bus.busy), 32'd0);

        // Kill during HOLD extends the pulse, no extra count
        do_reset();
        bus.kill_vec = 3'b001;
        @(negedge clk);
        bus.kill_vec = 3'b000;
        @(negedge clk);
        bus.kill_vec = 3'b100;
        @(negedge clk);
        bus.kill_vec = 3'b000;
        count_high(hi);
        check("t2_rst_len", 32'(hi + 2), 32'd6);
        check("t2_cause",   32'(bus.rst_cause), 32'h5);
        check("t2_viol",    32'(bus.viol_cnt),  32'd1);
        go_idle();

        // Handler never reached -> timeout re-pulse
        do_reset();
        pulse_kill(3'b001);
        count_high(hi);
        w = 0;
        while (!bus.cpu_rst && bus.busy && w < 200) begin
            w++;
            @(negedge clk);
        end
        check("t3_wait_len", 32'(w), 32'd64);
        check("t3_tflag",    32'(bus.timeout_flag), 32'd1);
        check("t3_viol",     32'(bus.viol_cnt),     32'd2);
        count_high(hi);
        check("t3_rst_len",  32'(hi), 32'd4);
        go_idle();
        check("t3_tflag_sticky", 32'(bus.timeout_flag), 32'd1);

        // Clear gating by SMEM range
        do_reset();
        pulse_kill(3'b011);
        go_idle();
        bus.clr_req = 1'b1;
        bus.pc      = 16'h1000;
        @(negedge clk);
        check("t4_clr_out", 32'(bus.rst_cause), 32'h3);
        bus.pc = 16'hDFFF;
        @(negedge clk);
        check("t4_clr_dfff", 32'(bus.rst_cause), 32'h3);
        bus.pc = 16'hA100;
        @(negedge clk);
        bus.clr_req = 1'b0;
        check("t4_clr_in",   32'(bus.rst_cause), 32'h0);
        check("t4_clr_viol", 32'(bus.viol_cnt),  32'd1);
        pulse_kill(3'b011);
        go_idle();
        bus.clr_req  = 1'b1;
        bus.pc       = 16'hA100;
        bus.kill_vec = 3'b100;
        @(negedge clk);
        bus.clr_req  = 1'b0;
        bus.kill_vec = 3'b000;
        check("t4_prio_cause", 32'(bus.rst_cause), 32'h7);
        check("t4_prio_busy",  32'(bus.busy),      32'd1);
        check("t4_prio_viol",  32'(bus.viol_cnt),  32'd3);
        go_idle();

        // Asynchronous reset mid-HOLD
        pulse_kill(3'b010);
        #2 reset = 1'b1;
        #1;
        check("t5_cpu_rst", 32'(bus.cpu_rst),      32'd0);
        check("t5_busy",    32'(bus.busy),         32'd0);
        check("t5_cause",   32'(bus.rst_cause),    32'd0);
        check("t5_viol",    32'(bus.viol_cnt),     32'd0);
        check("t5_tflag",   32'(bus.timeout_flag), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Saturation over 260 episodes
        for (int i = 0; i < 260; i++) begin
            pulse_kill(3'(1 << (i % 3)));
            go_idle();
        end
        check("t6_sat", 32'(bus.viol_cnt), 32'hFF);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            int r;
            bus.kill_vec = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            bus.clr_req  = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 7);
            case (r)
                0, 1:    bus.pc = 16'hfffe;
                2:       bus.pc = 16'($urandom_range(16'hA000, 16'hDFFE));
                3:       bus.pc = 16'hA000;
                4:       bus.pc = 16'hDFFE;
                5:       bus.pc = 16'hE000;
                6:       bus.pc = 16'h9FFE;
                default: bus.pc = 16'($urandom);
            endcase
            @(negedge clk);
        end
        bus.kill_vec = 3'b000;
        bus.clr_req  = 1'b0;
        go_idle();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
